// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - state type, size encodings and byte-count helper for sram_ctrl
package sram_ctrl_pkg;

  // Controller states; TURN is only reachable when SRAM_CTRL_TURNAROUND_EN is defined
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4,
    ST_TURN   = 3'd5
  } state_t;

  // Transfer size encoding on hb_i (2'b11 behaves as a word)
  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  // Number of SRAM byte cycles a transfer of the given size needs
  function automatic logic [2:0] byte_count(input logic [1:0] hb);
    case (hb)
      HB_BYTE: byte_count = 3'd1;
      HB_HALF: byte_count = 3'd2;
      HB_WORD: byte_count = 3'd4;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - byte-serial async SRAM controller; SRAM_CTRL_TURNAROUND_EN adds a bus turnaround cycle after reads
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        hb_i,
  input  logic              uload_i,
  output logic              gnt_o,
  output logic [31:0]       rdata_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [7:0]        mem_db_o,
  output logic              mem_db_oe_o,
  input  logic [7:0]        mem_db_i,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o
);

  localparam logic [3:0] LP_WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic [1:0]          r_idx;
  logic [1:0]          w_idx_nxt;
  logic [2:0]          r_nbytes;
  logic                r_we;
  logic [ADDR_W-1:0]   r_base;
  logic [31:0]         r_wdata;
  logic [1:0]          r_hb;
  logic                r_uload;
  logic [31:0]         r_rbuf;

  logic                r_gnt;
  logic [31:0]         r_rdata;
  logic [ADDR_W-1:0]   r_adr;
  logic [7:0]          r_db;
  logic                r_db_oe;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;

  logic                w_accept;
  logic                w_sample;
  logic                w_last;
  logic                w_we;
  logic [ADDR_W-1:0]   w_base;
  logic [31:0]         w_wdata;
  logic                w_active_nxt;
  logic                w_drive_nxt;
  logic [31:0]         w_rd_result;
  logic                w_unused_addr;

  assign w_unused_addr = ^addr_i[31:ADDR_W];

  // The byte just finished in HOLD is the last one of the transfer
  assign w_last = ({1'b0, r_idx} == (r_nbytes - 3'd1));

  // On the accepting edge the request fields are not latched yet, so use them directly
  assign w_we    = w_accept ? we_i : r_we;
  assign w_base  = w_accept ? addr_i[ADDR_W-1:0] : r_base;
  assign w_wdata = w_accept ? wdata_i : r_wdata;

  // Strobes and bus drive are registered from the next state so they align with it
  assign w_active_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS) ||
                        (w_state_nxt == ST_HOLD);
  assign w_drive_nxt  = w_we && ((w_state_nxt == ST_ACCESS) || (w_state_nxt == ST_HOLD));

  // Next-state, wait counter and byte index sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_i && ce_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
          w_idx_nxt   = 2'd0;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
        w_cnt_nxt   = LP_WAIT_LAST;
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_HOLD;
          w_sample    = ~r_we;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_DONE: begin
`ifdef SRAM_CTRL_TURNAROUND_EN
        w_state_nxt = r_we ? ST_IDLE : ST_TURN;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sign- or zero-extend byte and half reads; words pass through
  always_comb begin
    w_rd_result = r_rbuf;
    case (r_hb)
      HB_BYTE: w_rd_result = r_uload ? {24'h0, r_rbuf[7:0]} : {{24{r_rbuf[7]}}, r_rbuf[7:0]};
      HB_HALF: w_rd_result = r_uload ? {16'h0, r_rbuf[15:0]} : {{16{r_rbuf[15]}}, r_rbuf[15:0]};
      default: w_rd_result = r_rbuf;
    endcase
  end

  // FSM state, request latch and read byte-lane assembly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= 2'd0;
      r_nbytes <= 3'd1;
      r_we     <= 1'b0;
      r_base   <= '0;
      r_wdata  <= 32'h0;
      r_hb     <= HB_BYTE;
      r_uload  <= 1'b0;
      r_rbuf   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_nbytes <= byte_count(hb_i);
        r_we     <= we_i;
        r_base   <= addr_i[ADDR_W-1:0];
        r_wdata  <= wdata_i;
        r_hb     <= hb_i;
        r_uload  <= uload_i;
        r_rbuf   <= 32'h0;
      end
      if (w_sample) begin
        r_rbuf[{r_idx, 3'b000} +: 8] <= mem_db_i;
      end
    end
  end

  // Registered SRAM strobes, address, write data and completion outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt   <= 1'b0;
      r_rdata <= 32'h0;
      r_adr   <= '0;
      r_db    <= 8'h0;
      r_db_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
    end else begin
      r_ce_n  <= ~w_active_nxt;
      r_oe_n  <= ~((w_state_nxt == ST_ACCESS) && !w_we);
      r_we_n  <= ~((w_state_nxt == ST_ACCESS) && w_we);
      r_db_oe <= w_drive_nxt;
      r_db    <= w_drive_nxt ? w_wdata[{w_idx_nxt, 3'b000} +: 8] : 8'h0;
      if (w_active_nxt) begin
        r_adr <= w_base + ADDR_W'(w_idx_nxt);
      end
      r_gnt   <= (w_state_nxt == ST_DONE);
      r_rdata <= ((w_state_nxt == ST_DONE) && !r_we) ? w_rd_result : 32'h0;
    end
  end

  assign gnt_o       = r_gnt;
  assign rdata_o     = r_rdata;
  assign mem_adr_o   = r_adr;
  assign mem_db_o    = r_db;
  assign mem_db_oe_o = r_db_oe;
  assign ram_ce_n_o  = r_ce_n;
  assign ram_oe_n_o  = r_oe_n;
  assign ram_we_n_o  = r_we_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - randomized self-checking bench for sram_ctrl against a byte-array SRAM model
module tb_sram_ctrl;

  localparam int W     = 2;
  localparam int AW    = 19;
  localparam int MEMSZ = 1 << AW;
  localparam logic [31:0] AMASK = 32'(MEMSZ - 1);
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int B2B_GAP = 3;
`else
  localparam int B2B_GAP = 2;
`endif

  logic          clk;
  logic          rst_i, req_i, ce_i, we_i, uload_i;
  logic [31:0]   addr_i, wdata_i;
  logic [1:0]    hb_i;
  logic          gnt_o, mem_db_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o;
  logic [31:0]   rdata_o;
  logic [AW-1:0] mem_adr_o;
  logic [7:0]    mem_db_o, mem_db_i;

  sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .ce_i(ce_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .hb_i(hb_i), .uload_i(uload_i),
    .gnt_o(gnt_o), .rdata_o(rdata_o), .mem_adr_o(mem_adr_o), .mem_db_o(mem_db_o),
    .mem_db_oe_o(mem_db_oe_o), .mem_db_i(mem_db_i), .ram_ce_n_o(ram_ce_n_o),
    .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sram: the external device as the DUT writes it; ref_mem: what the bench intended to write
  bit [7:0] sram    [0:MEMSZ-1];
  bit [7:0] ref_mem [0:MEMSZ-1];

  assign mem_db_i = !ram_oe_n_o ? sram[mem_adr_o] : 8'h00;

  always @(posedge clk) begin
    if (!rst_i && !ram_we_n_o && !ram_ce_n_o && mem_db_oe_o) sram[mem_adr_o] = mem_db_o;
  end

  int n_err = 0;
  int n_chk = 0;

  logic [AW-1:0] ev_adr[$];
  logic [7:0]    ev_dat[$];
  int            ev_len[$];
  logic [AW-1:0] rd_adr[$];
  int            rd_len[$];
  int            viol;
  int            gnt_c;
  logic [31:0]   got_rdata;

  function automatic int nbytes(input logic [1:0] hb);
    return (hb == 2'b00) ? 1 : (hb == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [1:0] hb, input logic ul);
    logic [31:0] v;
    int n;
    n = nbytes(hb);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'((a + 32'(k)) & AMASK)]) << (8 * k));
    if (n == 1 && !ul && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !ul && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic idle(input int n);
    req_i = 1'b0;
    ce_i  = 1'($urandom_range(0, 1));
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue one transaction, scramble the inputs afterwards and record what appears on the SRAM pins
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] hb, input logic ul);
    int c, wrun, rrun;
    logic [AW-1:0] wa, ra;
    logic [7:0] wd;
    idle(2);
    ev_adr.delete(); ev_dat.delete(); ev_len.delete(); rd_adr.delete(); rd_len.delete();
    viol = 0; gnt_c = -1; got_rdata = 32'hx;
    we_i = we; addr_i = a; wdata_i = d; hb_i = hb; uload_i = ul; req_i = 1'b1; ce_i = 1'b1;
    @(posedge clk); #1;
    c = 1; wrun = 0; rrun = 0; wa = '0; ra = '0; wd = 8'h0;
    while (c <= 200) begin
      req_i = 1'($urandom_range(0, 1)); ce_i = 1'($urandom_range(0, 1));
      we_i = 1'($urandom_range(0, 1)); addr_i = $urandom; wdata_i = $urandom;
      hb_i = 2'($urandom_range(0, 3)); uload_i = 1'($urandom_range(0, 1));
      if (!ram_oe_n_o && !ram_we_n_o) viol++;
      if ((!ram_oe_n_o || !ram_we_n_o) && ram_ce_n_o) viol++;
      if (mem_db_oe_o && !we) viol++;
      if (gnt_o && !ram_ce_n_o) viol++;
      if (!ram_we_n_o) begin
        if (!mem_db_oe_o) viol++;
        if (wrun == 0) begin
          wa = mem_adr_o; wd = mem_db_o;
          ev_adr.push_back(wa); ev_dat.push_back(wd);
        end else if (mem_adr_o !== wa || mem_db_o !== wd) viol++;
        wrun++;
      end else if (wrun > 0) begin
        ev_len.push_back(wrun);
        wrun = 0;
        if (!mem_db_oe_o || ram_ce_n_o || mem_adr_o !== wa || mem_db_o !== wd) viol++;
      end
      if (!ram_oe_n_o) begin
        if (rrun == 0) begin ra = mem_adr_o; rd_adr.push_back(ra); end
        else if (mem_adr_o !== ra) viol++;
        rrun++;
      end else if (rrun > 0) begin
        rd_len.push_back(rrun);
        rrun = 0;
        if (ram_ce_n_o || mem_adr_o !== ra) viol++;
      end
      if (gnt_o) begin gnt_c = c; got_rdata = rdata_o; break; end
      @(posedge clk); #1;
      c++;
    end
    req_i = 1'b0;
    if (we) for (int k = 0; k < nbytes(hb); k++) ref_mem[int'((a + 32'(k)) & AMASK)] = d[8*k +: 8];
  endtask

  task automatic test_reset;
    rst_i = 1'b1; req_i = 1'b1; ce_i = 1'b1; we_i = 1'b1; addr_i = $urandom;
    wdata_i = $urandom; hb_i = 2'b10; uload_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_chk++; if (ram_ce_n_o !== 1'b1) begin n_err++; $display("FAIL reset_ce_n got=%b exp=1", ram_ce_n_o); end
    n_chk++; if (ram_oe_n_o !== 1'b1) begin n_err++; $display("FAIL reset_oe_n got=%b exp=1", ram_oe_n_o); end
    n_chk++; if (ram_we_n_o !== 1'b1) begin n_err++; $display("FAIL reset_we_n got=%b exp=1", ram_we_n_o); end
    n_chk++; if (mem_db_oe_o !== 1'b0) begin n_err++; $display("FAIL reset_db_oe got=%b exp=0", mem_db_oe_o); end
    n_chk++; if (gnt_o !== 1'b0) begin n_err++; $display("FAIL reset_gnt got=%b exp=0", gnt_o); end
    n_chk++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    n_chk++; if (mem_adr_o !== '0 || mem_db_o !== 8'h0) begin
      n_err++; $display("FAIL reset_adr_db got=%h/%h exp=0/0", mem_adr_o, mem_db_o);
    end
    req_i = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic test_word_write;
    logic [7:0] eb [4];
    eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE;
    run_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b0);
    n_chk++; if (gnt_c !== 17) begin n_err++; $display("FAIL word_write_gnt_cycle got=%0d exp=17", gnt_c); end
    n_chk++; if (ev_adr.size() !== 4 || ev_len.size() !== 4) begin
      n_err++; $display("FAIL word_write_pulses got=%0d/%0d exp=4", ev_adr.size(), ev_len.size());
    end
    for (int k = 0; k < ev_adr.size() && k < 4 && k < ev_len.size(); k++) begin
      n_chk++;
      if (ev_adr[k] !== AW'(32'h100 + 32'(k)) || ev_dat[k] !== eb[k] || ev_len[k] !== 2) begin
        n_err++;
        $display("FAIL word_write_byte%0d got adr=%h dat=%h len=%0d exp adr=%h dat=%h len=2",
                 k, ev_adr[k], ev_dat[k], ev_len[k], 32'h100 + 32'(k), eb[k]);
      end
    end
    n_chk++; if (got_rdata !== 32'h0) begin n_err++; $display("FAIL word_write_rdata got=%h exp=0", got_rdata); end
    n_chk++; if (viol !== 0) begin n_err++; $display("FAIL word_write_protocol got=%0d exp=0", viol); end
  endtask

  task automatic test_byte_read;
    run_txn(1'b1, 32'h0000_0080, 32'h0000_0080, 2'b00, 1'b0);
    run_txn(1'b0, 32'h0000_0080, $urandom, 2'b00, 1'b0);
    n_chk++; if (gnt_c !== 5) begin n_err++; $display("FAIL byte_read_s_gnt_cycle got=%0d exp=5", gnt_c); end
    n_chk++; if (got_rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL byte_read_s got=%h exp=ffffff80", got_rdata); end
    run_txn(1'b0, 32'h0000_0080, $urandom, 2'b00, 1'b1);
    n_chk++; if (gnt_c !== 5) begin n_err++; $display("FAIL byte_read_u_gnt_cycle got=%0d exp=5", gnt_c); end
    n_chk++; if (got_rdata !== 32'h0000_0080) begin n_err++; $display("FAIL byte_read_u got=%h exp=00000080", got_rdata); end
    n_chk++; if (rd_adr.size() !== 1 || rd_len.size() !== 1 || viol !== 0) begin
      n_err++; $display("FAIL byte_read_strobes got=%0d reads viol=%0d exp=1 reads viol=0", rd_adr.size(), viol);
    end
  endtask

  task automatic test_half_wrap;
    run_txn(1'b1, 32'h0007_FFFF, 32'h0000_1234, 2'b01, 1'b0);
    n_chk++; if (ev_adr.size() !== 2 || ev_adr[0] !== AW'('h7FFFF) || ev_adr[1] !== AW'('h0) ||
                 ev_dat[0] !== 8'h34 || ev_dat[1] !== 8'h12) begin
      n_err++; $display("FAIL half_wrap_write got %0d pulses exp 7ffff:34 00000:12", ev_adr.size());
    end
    run_txn(1'b0, 32'h0007_FFFF, 32'h0, 2'b01, 1'b0);
    n_chk++; if (rd_adr.size() !== 2 || rd_adr[0] !== AW'('h7FFFF) || rd_adr[1] !== AW'('h0)) begin
      n_err++; $display("FAIL half_wrap_read_addr got %0d reads exp 7ffff then 00000", rd_adr.size());
    end
    n_chk++; if (got_rdata !== 32'h0000_1234) begin n_err++; $display("FAIL half_wrap_rdata got=%h exp=00001234", got_rdata); end
    n_chk++; if (gnt_c !== 9) begin n_err++; $display("FAIL half_wrap_gnt_cycle got=%0d exp=9", gnt_c); end
  endtask

  task automatic test_random;
    logic we, ul;
    logic [1:0] hb;
    logic [31:0] a, d, er;
    int n, eg;
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1)); ul = 1'($urandom_range(0, 1)); hb = 2'($urandom_range(0, 3));
      a  = ((t % 3 == 0) ? 32'h0007_FFF8 : 32'h0000_2000) + 32'($urandom_range(0, 15));
      a  = a | ($urandom & 32'hFFF0_0000);
      d  = $urandom;
      n  = nbytes(hb);
      eg = n * (W + 2) + 1;
      er = we ? 32'h0 : exp_read(a, hb, ul);
      run_txn(we, a, d, hb, ul);
      n_chk++; if (gnt_c !== eg) begin n_err++; $display("FAIL rand%0d_gnt_cycle got=%0d exp=%0d", t, gnt_c, eg); end
      n_chk++; if (got_rdata !== er) begin n_err++; $display("FAIL rand%0d_rdata got=%h exp=%h", t, got_rdata, er); end
      n_chk++; if (viol !== 0) begin n_err++; $display("FAIL rand%0d_protocol got=%0d exp=0", t, viol); end
      if (we) begin
        n_chk++; if (ev_adr.size() !== n || ev_len.size() !== n || rd_adr.size() !== 0) begin
          n_err++; $display("FAIL rand%0d_write_count got=%0d exp=%0d", t, ev_adr.size(), n);
        end
        for (int k = 0; k < n && k < ev_adr.size() && k < ev_len.size(); k++) begin
          n_chk++;
          if (ev_adr[k] !== AW'((a + 32'(k)) & AMASK) || ev_dat[k] !== d[8*k +: 8] || ev_len[k] !== W) begin
            n_err++;
            $display("FAIL rand%0d_wbyte%0d got adr=%h dat=%h len=%0d exp adr=%h dat=%h len=%0d", t, k,
                     ev_adr[k], ev_dat[k], ev_len[k], (a + 32'(k)) & AMASK, d[8*k +: 8], W);
          end
        end
      end else begin
        n_chk++; if (rd_adr.size() !== n || rd_len.size() !== n || ev_adr.size() !== 0) begin
          n_err++; $display("FAIL rand%0d_read_count got=%0d exp=%0d", t, rd_adr.size(), n);
        end
        for (int k = 0; k < n && k < rd_adr.size() && k < rd_len.size(); k++) begin
          n_chk++;
          if (rd_adr[k] !== AW'((a + 32'(k)) & AMASK) || rd_len[k] !== W) begin
            n_err++;
            $display("FAIL rand%0d_rbyte%0d got adr=%h len=%0d exp adr=%h len=%0d", t, k,
                     rd_adr[k], rd_len[k], (a + 32'(k)) & AMASK, W);
          end
        end
      end
    end
  endtask

  task automatic test_reset_abort;
    int c, g, early_gnt;
    logic [31:0] er;
    er = exp_read(32'h80, 2'b00, 1'b0);
    idle(2);
    we_i = 1'b1; addr_i = 32'h0000_0300; wdata_i = $urandom; hb_i = 2'b10; uload_i = 1'b0;
    req_i = 1'b1; ce_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0; c = 1; early_gnt = 0;
    while (c < 6) begin @(posedge clk); #1; c++; if (gnt_o) early_gnt++; end
    n_chk++; if (ram_we_n_o !== 1'b0 || mem_adr_o !== AW'('h301)) begin
      n_err++; $display("FAIL abort_in_byte1 got we_n=%b adr=%h exp we_n=0 adr=00301", ram_we_n_o, mem_adr_o);
    end
    rst_i = 1'b1; req_i = 1'b1; ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0080; hb_i = 2'b00; uload_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    n_chk++; if (ram_ce_n_o !== 1'b1 || ram_oe_n_o !== 1'b1 || ram_we_n_o !== 1'b1 || mem_db_oe_o !== 1'b0 || gnt_o !== 1'b0) begin
      n_err++; $display("FAIL abort_outputs got ce/oe/we/dboe/gnt=%b%b%b%b%b exp=11100",
                        ram_ce_n_o, ram_oe_n_o, ram_we_n_o, mem_db_oe_o, gnt_o);
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    n_chk++; if (ram_ce_n_o !== 1'b0 || ram_we_n_o !== 1'b1 || ram_oe_n_o !== 1'b1 || mem_adr_o !== AW'('h80)) begin
      n_err++; $display("FAIL abort_next_accept got ce_n=%b adr=%h exp ce_n=0 adr=00080", ram_ce_n_o, mem_adr_o);
    end
    c = 1; g = -1;
    while (c <= 40) begin
      if (gnt_o) begin g = c; break; end
      @(posedge clk); #1; c++;
    end
    n_chk++; if (g !== 5 || early_gnt !== 0) begin
      n_err++; $display("FAIL abort_no_gnt got first_gnt=%0d early=%0d exp first_gnt=5 early=0", g, early_gnt);
    end
    n_chk++; if (rdata_o !== er) begin n_err++; $display("FAIL abort_new_read got=%h exp=%h", rdata_o, er); end
  endtask

  task automatic test_no_ce;
    int bad;
    idle(2);
    bad = 0;
    req_i = 1'b1; ce_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      we_i = 1'($urandom_range(0, 1)); addr_i = $urandom; hb_i = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      if (!ram_ce_n_o || !ram_oe_n_o || !ram_we_n_o || mem_db_oe_o || gnt_o) bad++;
    end
    req_i = 1'b0;
    n_chk++; if (bad !== 0) begin n_err++; $display("FAIL no_ce_activity got=%0d cycles exp=0", bad); end
  endtask

  task automatic test_back_to_back;
    int c, g, s, g2;
    logic [31:0] er;
    logic ok;
    run_txn(1'b1, 32'h0000_4100, 32'h0000_00C3, 2'b00, 1'b0);
    er = exp_read(32'h4100, 2'b00, 1'b0);
    idle(2);
    we_i = 1'b0; addr_i = 32'h0000_4100; hb_i = 2'b00; uload_i = 1'b0; req_i = 1'b1; ce_i = 1'b1;
    @(posedge clk); #1;
    we_i = 1'b1; addr_i = 32'h0000_4200; wdata_i = 32'h0000_005A; hb_i = 2'b00; uload_i = 1'b1;
    c = 1; g = -1; s = -1; g2 = -1; ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (gnt_o) begin
        if (g < 0) begin
          g = c;
          n_chk++; if (rdata_o !== er) begin n_err++; $display("FAIL b2b_read_rdata got=%h exp=%h", rdata_o, er); end
        end else if (s >= 0) g2 = c;
      end
      if (g >= 0 && s < 0 && c > g && !ram_ce_n_o) begin
        s = c; req_i = 1'b0;
        ok = (ram_we_n_o === 1'b1) && (ram_oe_n_o === 1'b1) && (mem_adr_o === AW'('h4200));
      end
      if (g2 >= 0) break;
      @(posedge clk); #1;
      c++;
    end
    req_i = 1'b0;
    ref_mem[32'h4200] = 8'h5A;
    n_chk++; if (g !== 5) begin n_err++; $display("FAIL b2b_read_gnt_cycle got=%0d exp=5", g); end
    n_chk++; if (g < 0 || s !== g + B2B_GAP) begin
      n_err++; $display("FAIL b2b_setup_gap got=%0d exp=%0d", s - g, B2B_GAP);
    end
    n_chk++; if (!ok) begin n_err++; $display("FAIL b2b_write_setup got adr=%h we_n=%b exp adr=04200 we_n=1", mem_adr_o, ram_we_n_o); end
    n_chk++; if (s < 0 || g2 !== s + 4) begin n_err++; $display("FAIL b2b_write_gnt got=%0d exp=%0d", g2, s + 4); end
    run_txn(1'b0, 32'h0000_4200, 32'h0, 2'b00, 1'b1);
    n_chk++; if (got_rdata !== 32'h0000_005A) begin n_err++; $display("FAIL b2b_readback got=%h exp=0000005a", got_rdata); end
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h0;
    wdata_i = 32'h0; hb_i = 2'b00; uload_i = 1'b0;
    test_reset();
    test_word_write();
    test_byte_read();
    test_half_wrap();
    test_random();
    test_reset_abort();
    test_no_ce();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: number of cycles each byte strobe is held low (legal range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 19: external SRAM address width.
REQ-003 SHALL have port clk_i, input, 1: the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-005 SHALL have port req_i, input, 1: bus request.
REQ-006 SHALL have port ce_i, input, 1: RAM region chip-select from the address decoder.
REQ-007 SHALL have port we_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port addr_i, input, 32: byte address; only [ADDR_W-1:0] is used.
REQ-009 SHALL have port wdata_i, input, 32: write data, LSB-aligned.
REQ-010 SHALL have port hb_i, input, 2: size; 00 = byte, 01 = half, 10/11 = word.
REQ-011 SHALL have port uload_i, input, 1: zero-extend reads when 1, sign-extend when 0.
REQ-012 SHALL have port gnt_o, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port rdata_o, output, 32: read data, valid while gnt_o is high.
REQ-014 SHALL have port mem_adr_o, output, ADDR_W: SRAM address.
REQ-015 SHALL have port mem_db_o, output, 8: data driven to the SRAM.
REQ-016 SHALL have port mem_db_oe_o, output, 1: tristate enable for MemDB (the top level builds the inout).
REQ-017 SHALL have port mem_db_i, input, 8: data sampled from the SRAM.
REQ-018 SHALL have ports ram_ce_n_o, ram_oe_n_o and ram_we_n_o, output, 1 each: active-low SRAM strobes.

Function
REQ-019 SHALL accept a request only in IDLE, when req_i&ce_i=1.
- On acceptance it latches we_i, addr_i, wdata_i, hb_i and uload_i.
- Input changes after acceptance are ignored until gnt_o.
REQ-020 SHALL ignore req_i when ce_i=0: no strobes, gnt_o stays 0.
REQ-021 SHALL transfer N bytes, with N = 1, 2 or 4 according to hb.
- Little-endian: byte k goes to address addr+k.
- mem_adr_o wraps modulo 2^ADDR_W.
- Misaligned addresses are legal.
REQ-022 SHALL use the FSM states IDLE -> SETUP -> ACCESS -> HOLD, then either SETUP for the next byte or DONE when the last byte is finished; DONE -> IDLE.
REQ-023 SETUP SHALL last 1 cycle: ram_ce_n_o=0, address stable, oe_n=1, we_n=1.
REQ-024 ACCESS SHALL last WAIT_CYCLES cycles, counted by a down-counter.
- Read: ram_oe_n_o=0.
- Write: ram_we_n_o=0, mem_db_oe_o=1, mem_db_o = the current byte.
REQ-025 A read SHALL sample mem_db_i on the last ACCESS cycle into byte lane k.
REQ-026 HOLD SHALL last 1 cycle: we_n=1, oe_n=1.
- ce_n and the address stay unchanged.
- On writes, mem_db_oe_o stays 1 for data hold time.
REQ-027 DONE SHALL last 1 cycle.
- gnt_o=1 and ram_ce_n_o=1.
- For reads, rdata_o carries the sign- or zero-extended result of a byte or half read.
- rdata_o for writes is 0.
REQ-028 gnt_o SHALL assert exactly N*(WAIT_CYCLES+2)+1 cycles after the accepting edge.
REQ-029 SHALL NOT accept a new request in the DONE cycle; the earliest next acceptance is the following IDLE cycle.
REQ-030 A req_i that drops mid-transaction SHALL NOT abort it; gnt_o still pulses.
REQ-031 mem_db_oe_o SHALL be 0 in every state except ACCESS and HOLD of a write.

Reset
REQ-032 On rst_i=1 at a clock edge, the block SHALL enter IDLE regardless of state, aborting any transfer.
REQ-033 The reset values SHALL be:
- ram_ce_n_o, ram_oe_n_o and ram_we_n_o = 1.
- mem_db_oe_o = 0.
- gnt_o = 0.
- rdata_o = 0, mem_adr_o = 0, mem_db_o = 0.
REQ-034 A transfer aborted by reset SHALL never produce gnt_o.

Configuration
REQ-035 With SRAM_CTRL_TURNAROUND_EN defined, the block SHALL insert one TURN cycle between DONE and IDLE whenever the completed transaction was a read.
- In TURN, all strobes are high, mem_db_oe_o=0 and gnt_o=0.
- Without the macro there is no TURN state, and DONE -> IDLE directly.

Structure
REQ-036 Package sram_ctrl_pkg SHALL hold:
- the state enum typedef;
- the hb encoding constants (HB_BYTE, HB_HALF, HB_WORD);
- the byte-count function.
REQ-037 SHALL be a single module with no sub-modules; the wait counter, byte index and lane steering are inline.

Verification (WAIT_CYCLES=2)
REQ-038 Word write: addr 0x100, data 0xDEADBEEF.
- Write pulses 0xEF, 0xBE, 0xAD, 0xDE at addresses 0x100..0x103.
- Each we_n low pulse is 2 cycles.
- gnt_o arrives 17 cycles after acceptance.
REQ-039 Byte read at 0x80 with the SRAM returning 0x80.
- uload=0 gives rdata_o 0xFFFFFF80.
- uload=1 gives 0x00000080.
- gnt_o arrives 5 cycles after acceptance in both cases.
REQ-040 Half read at 0x7FFFF, SRAM returning 0x34 then 0x12.
- Addresses 0x7FFFF then 0x00000.
- rdata_o = 0x00001234.
REQ-041 Reset during the ACCESS of byte 1 of a word write.
- Next cycle: all strobes high, mem_db_oe_o=0.
- No gnt_o is ever produced.
- A new request is accepted on the first cycle after reset.
REQ-042 req_i=1 with ce_i=0 for 20 cycles: strobes remain high and gnt_o remains 0.
REQ-043 Back-to-back byte read then byte write, with the new request held on req_i.
- With SRAM_CTRL_TURNAROUND_EN: the write SETUP starts 3 cycles after the read gnt_o.
- Without the macro: 2 cycles after.
